// File: rtl/sram_pkg.sv
// Shared constants and FSM state type for the banked SRAM.
// Also holds the default geometry: 8 banks x 64 rows x 128 bits.
package sram_pkg;

    localparam int SRAM_NUM_BANKS = 8;
    localparam int SRAM_ROWS      = 64;
    localparam int SRAM_DATA_W    = 128;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

endpackage

// File: rtl/sram_bank.sv
// Single-port SRAM bank with a per-bit write mask and a registered read port.
// Latency: read data appears one cycle after an enabled read. Backpressure: none, always accepts when enabled.
// rdata holds its value across writes and idle cycles; sync reset clears it.
module sram_bank
    import sram_pkg::*;
#(
    parameter  int ROWS   = SRAM_ROWS,
    parameter  int DATA_W = SRAM_DATA_W,
    localparam int ROW_W  = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ROW_W-1:0]  addr,
    input  logic [DATA_W-1:0] wmask,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [ROWS];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] wr_row_d;

    always_comb begin
        rdata_d  = rdata_q;
        wr_row_d = (mem_q[addr] & ~wmask) | (wdata & wmask);
        if (en && !we) begin
            rdata_d = mem_q[addr];
        end
    end

    // Storage has no reset so it maps onto a plain SRAM macro.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem_q[addr] <= wr_row_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sram_banked.sv
// Banked SRAM: NUM_BANKS single-port banks behind one valid/ready request port; optional zeroing sweep (SRAM_BANKED_INIT_EN).
// Latency: read response one cycle after accept. Backpressure: req_ready low only during the init sweep;
// responses cannot be stalled.
module sram_banked
    import sram_pkg::*;
#(
    parameter  int NUM_BANKS = SRAM_NUM_BANKS,
    parameter  int ROWS      = SRAM_ROWS,
    parameter  int DATA_W    = SRAM_DATA_W,
    localparam int BANK_W    = $clog2(NUM_BANKS),
    localparam int ROW_W     = $clog2(ROWS),
    localparam int ADDR_W    = BANK_W + ROW_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wmask,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              busy
);

`ifdef SRAM_BANKED_INIT_EN
    localparam state_t RST_STATE = INIT;
`else
    localparam state_t RST_STATE = READY;
`endif

    state_t              state_q, state_d;
    logic [ROW_W-1:0]    row_cnt_q, row_cnt_d;
    logic                resp_valid_q, resp_valid_d;
    logic [BANK_W-1:0]   rd_bank_q, rd_bank_d;

    logic                accept;
    logic                sweep;
    logic [BANK_W-1:0]   req_bank;
    logic [ROW_W-1:0]    req_row;
    logic [NUM_BANKS-1:0] bank_en;
    logic                bank_we;
    logic [ROW_W-1:0]    bank_row;
    logic [DATA_W-1:0]   bank_wmask;
    logic [DATA_W-1:0]   bank_wdata;
    logic [DATA_W-1:0]   bank_rdata [NUM_BANKS];

    always_comb begin
        req_ready    = (state_q == READY);
        sweep        = (state_q == INIT);
        accept       = req_valid && req_ready;
        req_bank     = req_addr[ADDR_W-1 -: BANK_W];
        req_row      = req_addr[ROW_W-1:0];

        state_d      = state_q;
        row_cnt_d    = row_cnt_q;
        resp_valid_d = accept && !req_write;
        rd_bank_d    = rd_bank_q;

        // Bank index is captured so the response mux lines up with the bank's registered read.
        if (accept && !req_write) begin
            rd_bank_d = req_bank;
        end

        case (state_q)
            INIT: begin
                row_cnt_d = row_cnt_q + ROW_W'(1);
                if (row_cnt_q == ROW_W'(ROWS - 1)) begin
                    state_d   = READY;
                    row_cnt_d = '0;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase
    end

    // The sweep drives every bank at once with a zero row; otherwise only the addressed bank is enabled.
    always_comb begin
        bank_we    = sweep | req_write;
        bank_row   = sweep ? row_cnt_q : req_row;
        bank_wmask = sweep ? '1 : req_wmask;
        bank_wdata = sweep ? '0 : req_wdata;
        bank_en    = '0;
        if (sweep) begin
            bank_en = '1;
        end else if (accept) begin
            bank_en[req_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RST_STATE;
            row_cnt_q    <= '0;
            resp_valid_q <= 1'b0;
            rd_bank_q    <= '0;
        end else begin
            state_q      <= state_d;
            row_cnt_q    <= row_cnt_d;
            resp_valid_q <= resp_valid_d;
            rd_bank_q    <= rd_bank_d;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        sram_bank #(
            .ROWS   (ROWS),
            .DATA_W (DATA_W)
        ) u_bank (
            .clk   (clk),
            .rst   (rst),
            .en    (bank_en[b]),
            .we    (bank_we),
            .addr  (bank_row),
            .wmask (bank_wmask),
            .wdata (bank_wdata),
            .rdata (bank_rdata[b])
        );
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = bank_rdata[rd_bank_q];

`ifdef SRAM_BANKED_INIT_EN
    assign busy = sweep;
`else
    assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_sram_banked.sv
// Self-checking bench for sram_banked at default geometry (8 x 64 x 128).
// Adapts to SRAM_BANKED_INIT_EN: checks the sweep when defined, otherwise pre-zeroes memory itself.
module tb_sram_banked;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [8:0]   req_addr;
    logic [127:0] req_wmask;
    logic [127:0] req_wdata;
    logic         resp_valid;
    logic [127:0] resp_rdata;
    logic         busy;

    int           n_checks = 0;
    int           n_pass   = 0;
    logic [127:0] last_rdata = '0;
    logic         busy_seen = 1'b0;

    typedef struct {
        bit           wr;
        logic [8:0]   addr;
        logic [127:0] mask;
        logic [127:0] wdata;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [11];

    sram_banked dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wmask  (req_wmask),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy === 1'b1) busy_seen <= 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wmask = '0;
        req_wdata = '0;
        cyc();
        rst = 1'b0;
        last_rdata = '0;
    endtask

    task automatic do_write(input logic [8:0] a, input logic [127:0] m, input logic [127:0] d, input bit chk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = a;
        req_wmask = m;
        req_wdata = d;
        cyc();
        req_valid = 1'b0;
        if (chk) begin
            check("write gives no resp_valid", {127'b0, resp_valid}, 128'd0);
            check("write keeps resp_rdata", resp_rdata, last_rdata);
        end
    endtask

    task automatic do_read(input logic [8:0] a, input logic [127:0] exp, input string name);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = a;
        req_wmask = '0;
        req_wdata = '0;
        cyc();
        req_valid = 1'b0;
        check({name, " resp_valid"}, {127'b0, resp_valid}, 128'd1);
        check({name, " rdata"}, resp_rdata, exp);
        last_rdata = exp;
    endtask

    // Holds a read request up while busy; nothing may be accepted or answered during the sweep.
    task automatic wait_init(input string name, input int exp_cycles);
        int cnt = 0;
        int bad = 0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = '0;
        while (busy === 1'b1 && cnt < 200) begin
            if (req_ready !== 1'b0 || resp_valid !== 1'b0) bad++;
            cnt++;
            cyc();
        end
        req_valid = 1'b0;
        check({name, " busy cycles"}, 128'(cnt), 128'(exp_cycles));
        check({name, " quiet while busy"}, 128'(bad), 128'd0);
        check({name, " ready after"}, {127'b0, req_ready}, 128'd1);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 9'h1FF, 128'h0, 128'h0, 128'h0};
        vecs[1]  = '{1'b1, 9'h045, 128'hFF, {128{1'b1}}, 128'h0};
        vecs[2]  = '{1'b0, 9'h045, 128'h0, 128'h0, 128'hFF};
        vecs[3]  = '{1'b1, 9'h0C5, {128{1'b1}}, 128'hDEAD, 128'h0};
        vecs[4]  = '{1'b0, 9'h105, 128'h0, 128'h0, 128'h0};
        vecs[5]  = '{1'b0, 9'h0C5, 128'h0, 128'h0, 128'hDEAD};
        vecs[6]  = '{1'b1, 9'h0C5, 128'hFFFF_0000, 128'hBEEF_0000, 128'h0};
        vecs[7]  = '{1'b0, 9'h0C5, 128'h0, 128'h0, 128'hBEEF_DEAD};
        vecs[8]  = '{1'b1, 9'h000, {128{1'b1}}, 128'h11, 128'h0};
        vecs[9]  = '{1'b1, 9'h040, {128{1'b1}}, 128'h22, 128'h0};
        vecs[10] = '{1'b1, 9'h080, {128{1'b1}}, 128'h33, 128'h0};

        do_reset();
        check("reset resp_valid", {127'b0, resp_valid}, 128'd0);
        check("reset resp_rdata", resp_rdata, 128'd0);

`ifdef SRAM_BANKED_INIT_EN
        check("reset busy", {127'b0, busy}, 128'd1);
        wait_init("init", 64);
`else
        check("no-init ready first cycle", {127'b0, req_ready}, 128'd1);
        check("no-init busy", {127'b0, busy}, 128'd0);
        for (int i = 0; i < 512; i++) begin
            do_write(9'(i), {128{1'b1}}, 128'h0, 1'b0);
        end
`endif

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].mask, vecs[i].wdata, 1'b1);
            else            do_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Back-to-back reads across three banks, one per cycle.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 9'h000;
        cyc();
        req_addr  = 9'h040;
        check("b2b0 resp_valid", {127'b0, resp_valid}, 128'd1);
        check("b2b0 rdata", resp_rdata, 128'h11);
        cyc();
        req_addr  = 9'h080;
        check("b2b1 resp_valid", {127'b0, resp_valid}, 128'd1);
        check("b2b1 rdata", resp_rdata, 128'h22);
        cyc();
        req_valid = 1'b0;
        check("b2b2 resp_valid", {127'b0, resp_valid}, 128'd1);
        check("b2b2 rdata", resp_rdata, 128'h33);
        cyc();
        check("b2b end resp_valid", {127'b0, resp_valid}, 128'd0);
        check("b2b end rdata held", resp_rdata, 128'h33);

        // Reset arriving with a read in flight must swallow the response.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 9'h0C5;
        rst       = 1'b1;
        cyc();
        rst       = 1'b0;
        req_valid = 1'b0;
        check("rst read resp_valid", {127'b0, resp_valid}, 128'd0);
        check("rst read rdata", resp_rdata, 128'd0);
        cyc();
        check("rst read late resp_valid", {127'b0, resp_valid}, 128'd0);
        last_rdata = '0;

`ifdef SRAM_BANKED_INIT_EN
        wait_init("reinit", 64);
        do_read(9'h0C5, 128'h0, "swept row");
        do_reset();
        repeat (30) cyc();
        check("mid-sweep busy", {127'b0, busy}, 128'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        wait_init("sweep restart", 64);
        do_read(9'h1FF, 128'h0, "final 1FF");
`else
        check("no-init ready after rst", {127'b0, req_ready}, 128'd1);
        do_read(9'h0C5, 128'hBEEF_DEAD, "persist");
        do_read(9'h045, 128'hFF, "persist 045");
        check("no-init busy never", {127'b0, busy_seen}, 128'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
